sram_pingpong_buf: RTL and testbench

- Parametrised double-buffered (ping-pong) SRAM store. One producer fills one bank while one consumer drains the other.
- Bank ownership is handed over by an explicit commit/release handshake instead of by external address-MSB steering.
- Sits between the weight/activation loaders and the PE array, replacing fixed-size 16-word x 152-bit double buffers.
- Banks are internal behavioural SRAMs with registered reads, using the same timing model as the existing sram macros.

---
 rtl/sram_pingpong_buf.sv | 118 +++++++++++
 tb/tb_sram_pingpong_buf.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pingpong_buf.sv
// sram_pingpong_buf: two-bank ping-pong SRAM buffer with commit/release bank handover
module sram_pingpong_buf #(
    parameter  int WIDTH  = 152,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              wr_commit,
    output logic              wr_ready,
    output logic              wr_bank,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_release,
    output logic              rd_avail,
    output logic              rd_bank,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_data_vld,
    output logic              err_wr,
    output logic              err_rd
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem0 [DEPTH];
    logic [WIDTH-1:0] r_mem1 [DEPTH];
    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_data_vld;
    logic             r_err_wr;
    logic             r_err_rd;

    logic       w_wr_ready;
    logic       w_rd_avail;
    logic       w_wr_addr_ok;
    logic       w_rd_addr_ok;
    logic       w_wr_fire;
    logic       w_rd_fire;
    logic       w_commit;
    logic       w_release;
    logic       w_wr_err;
    logic       w_rd_err;
    logic [1:0] w_full_nxt;

    assign w_wr_ready   = !r_full[r_wr_bank];
    assign w_rd_avail   = r_full[r_rd_bank];
    assign w_wr_addr_ok = {1'b0, wr_addr} < DEPTH_L;
    assign w_rd_addr_ok = {1'b0, rd_addr} < DEPTH_L;
    assign w_wr_fire    = wr_en & w_wr_ready & w_wr_addr_ok;
    assign w_rd_fire    = rd_en & w_rd_avail & w_rd_addr_ok;
    assign w_commit     = wr_commit & w_wr_ready;
    assign w_release    = rd_release & w_rd_avail;
    assign w_wr_err     = !w_wr_ready & ((wr_en & w_wr_addr_ok) | wr_commit);
    assign w_rd_err     = !w_rd_avail & ((rd_en & w_rd_addr_ok) | rd_release);

    assign wr_ready    = w_wr_ready;
    assign rd_avail    = w_rd_avail;
    assign wr_bank     = r_wr_bank;
    assign rd_bank     = r_rd_bank;
    assign rd_data     = r_rd_data;
    assign rd_data_vld = r_rd_data_vld;
    assign err_wr      = r_err_wr;
    assign err_rd      = r_err_rd;

    // commit and release always target different banks, so both updates can apply
    always_comb begin
        w_full_nxt = r_full;
        if (w_commit)
            w_full_nxt[r_wr_bank] = 1'b1;
        if (w_release)
            w_full_nxt[r_rd_bank] = 1'b0;
    end

    // bank 0 storage, written only while owned by the producer
    always_ff @(posedge CLK) begin
        if (w_wr_fire && !r_wr_bank)
            r_mem0[wr_addr] <= wr_data;
    end

    // bank 1 storage, written only while owned by the producer
    always_ff @(posedge CLK) begin
        if (w_wr_fire && r_wr_bank)
            r_mem1[wr_addr] <= wr_data;
    end

    // ownership flags, bank pointers and sticky error bits
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_err_wr  <= 1'b0;
            r_err_rd  <= 1'b0;
        end else begin
            r_full    <= w_full_nxt;
            r_wr_bank <= r_wr_bank ^ w_commit;
            r_rd_bank <= r_rd_bank ^ w_release;
            r_err_wr  <= r_err_wr | w_wr_err;
            r_err_rd  <= r_err_rd | w_rd_err;
        end
    end

    // registered read port; a read issued with release uses the pre-toggle bank
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_data     <= '0;
            r_rd_data_vld <= 1'b0;
        end else begin
            r_rd_data_vld <= w_rd_fire;
            if (w_rd_fire)
                r_rd_data <= r_rd_bank ? r_mem1[rd_addr] : r_mem0[rd_addr];
        end
    end
endmodule

// File: tb/tb_sram_pingpong_buf.sv
// tb_sram_pingpong_buf: directed self-checking bench for the ping-pong buffer
module tb_sram_pingpong_buf;
    localparam int WIDTH  = 152;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              wr_commit;
    logic              wr_ready;
    logic              wr_bank;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_release;
    logic              rd_avail;
    logic              rd_bank;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_data_vld;
    logic              err_wr;
    logic              err_rd;

    int n_checks = 0;
    int n_errors = 0;

    sram_pingpong_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
        .wr_ready(wr_ready), .wr_bank(wr_bank),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
        .rd_avail(rd_avail), .rd_bank(rd_bank), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
        .err_wr(err_wr), .err_rd(err_rd)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        wr_en = 0; wr_addr = 0; wr_data = 0; wr_commit = 0;
        rd_en = 0; rd_addr = 0; rd_release = 0;
    endtask

    task automatic do_reset;
        idle();
        RESET = 1;
        #2;
        RESET = 0;
        tick();
    endtask

    task automatic write(input int a, input logic [WIDTH-1:0] d);
        wr_en = 1; wr_addr = ADDR_W'(a); wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic commit;
        wr_commit = 1;
        tick();
        wr_commit = 0;
    endtask

    task automatic release_bank;
        rd_release = 1;
        tick();
        rd_release = 0;
    endtask

    task automatic read_chk(input string tag, input int a, input logic [WIDTH-1:0] exp);
        rd_en = 1; rd_addr = ADDR_W'(a);
        tick();
        rd_en = 0;
        check({tag, "_data"}, rd_data, exp);
        check({tag, "_vld"}, rd_data_vld, 1);
    endtask

    initial begin
        idle();
        RESET = 1;
        tick();
        tick();
        RESET = 0;
        tick();

        // reset state
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_avail", rd_avail, 0);
        check("rst_wr_bank", wr_bank, 0);
        check("rst_rd_bank", rd_bank, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_vld", rd_data_vld, 0);
        check("rst_err_wr", err_wr, 0);
        check("rst_err_rd", err_rd, 0);

        // basic fill and drain
        for (int i = 0; i < DEPTH; i++) write(i, WIDTH'(32'h100 + i));
        check("fill_avail_pre", rd_avail, 0);
        commit();
        check("fill_avail", rd_avail, 1);
        check("fill_wr_bank", wr_bank, 1);
        check("fill_wr_ready", wr_ready, 1);
        for (int i = DEPTH - 1; i >= 0; i--) read_chk("drain", i, WIDTH'(32'h100 + i));
        tick();
        check("drain_vld_low", rd_data_vld, 0);
        check("drain_data_hold", rd_data, WIDTH'(32'h100));
        release_bank();
        check("rel_avail", rd_avail, 0);
        check("rel_wr_ready", wr_ready, 1);
        check("rel_rd_bank", rd_bank, 1);

        // ping-pong overlap
        do_reset();
        for (int i = 0; i < DEPTH; i++) write(i, WIDTH'(32'h100 + i));
        commit();
        check("pp_wr_bank1", wr_bank, 1);
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; wr_addr = ADDR_W'(i); wr_data = WIDTH'(32'h200 + i);
            read_chk("pp_b0", i, WIDTH'(32'h100 + i));
            wr_en = 0;
        end
        commit();
        check("pp_wr_bank0", wr_bank, 0);
        check("pp_wr_stall", wr_ready, 0);
        release_bank();
        check("pp_rd_bank1", rd_bank, 1);
        check("pp_wr_ready", wr_ready, 1);
        check("pp_avail", rd_avail, 1);
        for (int i = 0; i < DEPTH; i++) read_chk("pp_b1", i, WIDTH'(32'h200 + i));
        check("pp_err_wr", err_wr, 0);
        check("pp_err_rd", err_rd, 0);

        // full stall
        do_reset();
        for (int i = 0; i < DEPTH; i++) write(i, WIDTH'(32'h400 + i));
        commit();
        for (int i = 0; i < DEPTH; i++) write(i, WIDTH'(32'h500 + i));
        commit();
        check("full_wr_ready", wr_ready, 0);
        check("full_err_pre", err_wr, 0);
        write(2, WIDTH'(32'hDEAD));
        commit();
        check("full_err_wr", err_wr, 1);
        check("full_wr_bank", wr_bank, 0);
        for (int i = 0; i < DEPTH; i++) read_chk("full_b0", i, WIDTH'(32'h400 + i));
        release_bank();
        check("full_rd_bank", rd_bank, 1);
        for (int i = 0; i < DEPTH; i++) read_chk("full_b1", i, WIDTH'(32'h500 + i));
        release_bank();
        check("full_empty_avail", rd_avail, 0);
        check("full_empty_ready", wr_ready, 1);
        check("full_err_sticky", err_wr, 1);
        check("full_err_rd", err_rd, 0);

        // empty read
        do_reset();
        rd_en = 1; rd_addr = 3; rd_release = 1;
        tick();
        idle();
        check("empty_err_rd", err_rd, 1);
        check("empty_vld", rd_data_vld, 0);
        check("empty_data", rd_data, 0);
        check("empty_avail", rd_avail, 0);
        check("empty_wr_ready", wr_ready, 1);
        check("empty_rd_bank", rd_bank, 0);
        check("empty_err_wr", err_wr, 0);

        // simultaneous commit and release
        do_reset();
        for (int i = 0; i < DEPTH; i++) write(i, WIDTH'(32'h600 + i));
        commit();
        wr_en = 1; wr_addr = 5; wr_data = WIDTH'(32'h777); wr_commit = 1;
        rd_en = 1; rd_addr = 4; rd_release = 1;
        tick();
        idle();
        check("sim_rd_data", rd_data, WIDTH'(32'h604));
        check("sim_vld", rd_data_vld, 1);
        check("sim_wr_bank", wr_bank, 0);
        check("sim_rd_bank", rd_bank, 1);
        check("sim_avail", rd_avail, 1);
        check("sim_wr_ready", wr_ready, 1);
        read_chk("sim_b1", 5, WIDTH'(32'h777));
        check("sim_err_wr", err_wr, 0);
        check("sim_err_rd", err_rd, 0);

        // asynchronous reset mid-operation
        do_reset();
        write(3, WIDTH'(32'h800));
        commit();
        write(3, WIDTH'(32'h880));
        commit();
        read_chk("arst_pre", 3, WIDTH'(32'h800));
        #2;
        RESET = 1;
        #1;
        check("arst_data", rd_data, 0);
        check("arst_vld", rd_data_vld, 0);
        check("arst_wr_ready", wr_ready, 1);
        check("arst_avail", rd_avail, 0);
        check("arst_wr_bank", wr_bank, 0);
        check("arst_rd_bank", rd_bank, 0);
        RESET = 0;
        tick();
        write(3, WIDTH'(32'h999));
        commit();
        read_chk("arst_post", 3, WIDTH'(32'h999));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
